// File: rtl/seq_adder.sv
// seq_adder: WIDTH-bit adder/subtractor that ripples CHUNK bits per clock,
// with a valid/ready handshake on both the operand side and the result side.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // b_q holds B already inverted for subtraction, so CALC only ever adds.
  logic [CHUNK-1:0] a_chunk [N];
  logic [CHUNK-1:0] b_chunk [N];
  logic [CHUNK:0]   chunk_sum;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chunk
      assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign chunk_sum = {1'b0, a_chunk[k_q]} + {1'b0, b_chunk[k_q]}
                   + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? ~cin : cin;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) s_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        end
        carry_d = chunk_sum[CHUNK];
        // k stays at N-1 on the final chunk so it never leaves 0..N-1.
        if (k_q == K_LAST) begin
          state_d = DONE;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Directed-vector and random-model bench for seq_adder at WIDTH=8, CHUNK=2.
module tb_seq_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] S;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int op_no  = 0;

  seq_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sb;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (op %0d): got %0h expected %0h", name, op_no, act, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic, no chunking or inversion.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sb, output logic [7:0] s, output logic co,
                       output logic ov);
    int sa;
    int sbv;
    int r;
    int ur;
    sa  = $signed(a);
    sbv = $signed(b);
    if (!sb) begin
      ur = int'(a) + int'(b) + int'(ci);
      r  = sa + sbv + int'(ci);
      co = (ur > 255);
    end else begin
      ur = int'(a) - int'(b) - int'(ci);
      r  = sa - sbv - int'(ci);
      co = (ur >= 0);
    end
    s  = 8'(ur);
    ov = (r > 127) || (r < -128);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sb, input logic [7:0] es, input logic eco,
                        input logic eov, input int hold);
    int lat;
    op_no++;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = ~b; cin = ~ci; sub = ~sb;
    check("in_ready_calc", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("S", 32'(S), 32'(es));
    check("cout", 32'(cout), 32'(eco));
    check("ovf", 32'(ovf), 32'(eov));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      A = 8'($urandom); B = 8'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_S", 32'(S), 32'(es));
      check("hold_flags", 32'({cout, ovf}), 32'({eco, eov}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_S_held", 32'(S), 32'(es));
    $display("op %0d: A=%h B=%h cin=%b sub=%b -> S=%h cout=%b ovf=%b lat=%0d",
             op_no, a, b, ci, sb, S, cout, ovf, lat);
  endtask

  initial begin
    logic [7:0] rs;
    logic       rco;
    logic       rov;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rci;
    logic       rsb;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({S, cout, ovf}), 32'd0);

    // Operand presented on the very first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb,
             vecs[i].s, vecs[i].co, vecs[i].ov, 0);
    end

    // Five cycles of backpressure with ignored in_valid pulses.
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5);

    // Reset after two CALC edges; partial S is nonzero, cout/ovf are 1.
    op_no++;
    A = 8'h12; B = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("midcalc_S_partial", 32'(S), 32'h06);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_outputs", 32'({S, cout, ovf}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_no_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    $display("op %0d: abandoned by reset", op_no);
    run_op(8'h21, 8'h43, 1'b1, 1'b0, 8'h65, 1'b0, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom);
      rsb = 1'($urandom);
      model(ra, rb, rci, rsb, rs, rco, rov);
      run_op(ra, rb, rci, rsb, rs, rco, rov, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
